// File: rtl/wm_pkg.sv
// Shared definitions for the washing-machine controller and its plant model:
// controller state encodings, default cycle constants and the dispenser state type.
package wm_pkg;

    localparam int WM_CNT_W    = 8;
    localparam int WM_FILL_CYC = 16;
    localparam int WM_DET_CYC  = 4;
    localparam int WM_WASH_CYC = 32;
    localparam int WM_SPIN_CYC = 24;

    typedef enum logic [2:0] {
        check_door,
        fill_water,
        add_detergent,
        cycle,
        drain_water,
        spin
    } wm_state_e;

    typedef enum logic [1:0] {
        IDLE,
        DOSING,
        DOSED
    } disp_state_e;

endpackage

// File: rtl/wm_plant_timer.sv
// Saturating cycle timer: counts while enabled, holds at LIMIT, clear wins over enable.
// The terminal flag is decoded from the registered count.
module wm_plant_timer #(
    parameter int CNT_W = 8,
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic clr_i,
    output logic term_o
);

    localparam logic [CNT_W-1:0] LIM = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: clear, else increment until the limit is reached.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LIM)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign term_o = (cnt_q == LIM);

endmodule

// File: rtl/iiitb_wm_plant.sv
// Cycle-level washing-machine appliance model. Turns controller actuator commands into
// the sensor signals the controller consumes, so the loop can be closed on-chip.
// Optional protocol checker: define WM_PLANT_FAULT_EN to build the sticky fault flag;
// without it fault is tied low and everything else is identical.
module iiitb_wm_plant
    import wm_pkg::*;
#(
    parameter int CNT_W    = WM_CNT_W,
    parameter int FILL_CYC = WM_FILL_CYC,
    parameter int DET_CYC  = WM_DET_CYC,
    parameter int WASH_CYC = WM_WASH_CYC,
    parameter int SPIN_CYC = WM_SPIN_CYC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             door_close_req,
    input  logic             door_open_req,
    input  logic             start_req,
    input  logic             door_lock,
    input  logic             motor_on,
    input  logic             fill_value_on,
    input  logic             drain_value_on,
    input  logic             soap_wash,
    input  logic             water_wash,
    input  logic             done,
    output logic             door_close,
    output logic             start,
    output logic             filled,
    output logic             detergent_added,
    output logic             cycle_timeout,
    output logic             drained,
    output logic             spin_timeout,
    output logic [CNT_W-1:0] level,
    output logic             fault
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(FILL_CYC);

    logic             door_q, door_d;
    logic             start_q;
    logic [CNT_W-1:0] level_q, level_d;
    disp_state_e      disp_q, disp_d;
    logic             used_q, used_d;
    logic             det_term;
    logic             spin_en;

    // Door latch: a lone close request closes, a lone open request opens unless locked.
    always_comb begin
        door_d = door_q;
        if (door_close_req && !door_open_req) begin
            door_d = 1'b1;
        end else if (door_open_req && !door_close_req && !door_lock) begin
            door_d = 1'b0;
        end
    end

    // Water level: fill or drain one unit per cycle, both valves together hold.
    always_comb begin
        level_d = level_q;
        if (fill_value_on && !drain_value_on && (level_q != FULL)) begin
            level_d = level_q + 1'b1;
        end else if (drain_value_on && !fill_value_on && (level_q != '0)) begin
            level_d = level_q - 1'b1;
        end
    end

    // Door, start and level registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            door_q  <= 1'b0;
            start_q <= 1'b0;
            level_q <= '0;
        end else begin
            door_q  <= door_d;
            start_q <= start_req;
            level_q <= level_d;
        end
    end

    // Dispenser next state; used_q blocks a second dose until the programme ends.
    always_comb begin
        disp_d = disp_q;
        used_d = used_q;
        case (disp_q)
            IDLE:    if (soap_wash && !water_wash && filled && !used_q) disp_d = DOSING;
            DOSING:  if (det_term) disp_d = DOSED;
            DOSED:   if (motor_on || done) disp_d = IDLE;
            default: disp_d = IDLE;
        endcase
        if (done) begin
            used_d = 1'b0;
        end else if ((disp_q == DOSING) && det_term) begin
            used_d = 1'b1;
        end
    end

    // Dispenser state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp_q <= IDLE;
            used_q <= 1'b0;
        end else begin
            disp_q <= disp_d;
            used_q <= used_d;
        end
    end

    // The dose timer runs from 0 on entry, so terminating at DET_CYC-1 gives DET_CYC dosing cycles.
    wm_plant_timer #(.CNT_W(CNT_W), .LIMIT(DET_CYC - 1)) u_det_timer (
        .clk    (clk),
        .reset  (reset),
        .en_i   (disp_q == DOSING),
        .clr_i  (disp_q != DOSING),
        .term_o (det_term)
    );

    wm_plant_timer #(.CNT_W(CNT_W), .LIMIT(WASH_CYC)) u_motor_timer (
        .clk    (clk),
        .reset  (reset),
        .en_i   (motor_on),
        .clr_i  (!motor_on),
        .term_o (cycle_timeout)
    );

    assign spin_en = drain_value_on && water_wash && (level_q == '0);

    wm_plant_timer #(.CNT_W(CNT_W), .LIMIT(SPIN_CYC)) u_spin_timer (
        .clk    (clk),
        .reset  (reset),
        .en_i   (spin_en),
        .clr_i  (!drain_value_on || done),
        .term_o (spin_timeout)
    );

`ifdef WM_PLANT_FAULT_EN
    logic fault_q;
    logic viol;

    assign viol = (fill_value_on && drain_value_on)
                || (fill_value_on && (level_q == FULL))
                || (door_open_req && door_lock)
                || (motor_on && !door_q);

    // Sticky protocol-violation flag, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)     fault_q <= 1'b0;
        else if (viol) fault_q <= 1'b1;
    end

    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    assign door_close      = door_q;
    assign start           = start_q && door_q;
    assign level           = level_q;
    assign filled          = (level_q == FULL);
    assign drained         = (level_q == '0);
    assign detergent_added = (disp_q == DOSED);

endmodule
